adxl_reg_seq: RTL

Register-access sequencer sitting directly upstream of the byte-level I2C controller. After power-up it verifies the accelerometer device ID, then writes a fixed three-entry configuration table. It then periodically reads the six data registers and presents assembled signed 16-bit X/Y/Z samples to downstream logic. Every bus transaction is exactly one single-byte register read or write issued over the controller's req/ack handshake.

---
 rtl/adxl_reg_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/adxl_reg_seq.sv
// adxl_reg_seq: register-access sequencer in front of a byte-level I2C controller.
//   Boots the accelerometer by checking its device ID (0xE5) and then writing a fixed
//   three-entry configuration table. After that it periodically reads the six data
//   registers 0x32..0x37 and publishes complete signed X/Y/Z samples.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                allows periodic read bursts
//   iicwr_req/iicrd_req   single-byte write/read request, held until iic_ack
//   iic_addr/iic_wrdb     register address / write data, stable while a request is up
//   iic_rddb/iic_ack      read data and one-cycle completion pulse from the controller
//   acc_x/acc_y/acc_z     latest sample set, updated atomically with data_valid
//   dev_id/id_err         byte read from register 0x00, sticky mismatch flag
//   init_done             sticky, configuration table written
//   busy                  a request is outstanding
module adxl_reg_seq #(
    parameter logic [23:0] INIT_WAIT   = 24'd2_000_000,
    parameter logic [23:0] POLL_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        iicwr_req,
    output logic        iicrd_req,
    output logic [7:0]  iic_addr,
    output logic [7:0]  iic_wrdb,
    input  logic [7:0]  iic_rddb,
    input  logic        iic_ack,
    output logic [15:0] acc_x,
    output logic [15:0] acc_y,
    output logic [15:0] acc_z,
    output logic        data_valid,
    output logic [7:0]  dev_id,
    output logic        id_err,
    output logic        init_done,
    output logic        busy
);
    typedef enum logic [2:0] {S_WAIT, S_ID, S_CHK, S_INIT, S_IDLE, S_READ, S_DONE, S_HALT} state_t;
    state_t      state, state_nx;
    logic [23:0] cnt, cnt_nx;
    logic [2:0]  idx, idx_nx;
    logic [47:0] stage, stage_nx;
    logic [15:0] acc_x_nx, acc_y_nx, acc_z_nx;
    logic [7:0]  addr_nx, wrdb_nx, dev_id_nx;
    logic        wr_nx, rd_nx, dv_nx, id_err_nx, init_done_nx;
    logic        busy_d, can_issue, acked, sat;
    assign busy = iicwr_req | iicrd_req;
    // busy_d guarantees at least two idle cycles between consecutive requests
    assign can_issue = !busy && !busy_d;
    assign acked = busy && iic_ack;
    assign sat = cnt == POLL_CYCLES - 24'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            cnt        <= '0;
            idx        <= '0;
            stage      <= '0;
            iicwr_req  <= 1'b0;
            iicrd_req  <= 1'b0;
            iic_addr   <= '0;
            iic_wrdb   <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            acc_z      <= '0;
            data_valid <= 1'b0;
            dev_id     <= '0;
            id_err     <= 1'b0;
            init_done  <= 1'b0;
            busy_d     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            stage      <= stage_nx;
            iicwr_req  <= wr_nx;
            iicrd_req  <= rd_nx;
            iic_addr   <= addr_nx;
            iic_wrdb   <= wrdb_nx;
            acc_x      <= acc_x_nx;
            acc_y      <= acc_y_nx;
            acc_z      <= acc_z_nx;
            data_valid <= dv_nx;
            dev_id     <= dev_id_nx;
            id_err     <= id_err_nx;
            init_done  <= init_done_nx;
            busy_d     <= busy;
        end
    end
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        idx_nx       = idx;
        stage_nx     = stage;
        wr_nx        = acked ? 1'b0 : iicwr_req;
        rd_nx        = acked ? 1'b0 : iicrd_req;
        addr_nx      = iic_addr;
        wrdb_nx      = iic_wrdb;
        acc_x_nx     = acc_x;
        acc_y_nx     = acc_y;
        acc_z_nx     = acc_z;
        dv_nx        = 1'b0;
        dev_id_nx    = dev_id;
        id_err_nx    = id_err;
        init_done_nx = init_done;
        case (state)
            S_WAIT: begin
                // the ID read is issued on the same edge that leaves WAIT
                if (cnt == INIT_WAIT - 24'd1) begin
                    state_nx = S_ID;
                    cnt_nx   = '0;
                    rd_nx    = 1'b1;
                    addr_nx  = 8'h00;
                end else begin
                    cnt_nx = cnt + 24'd1;
                end
            end
            S_ID: begin
                if (acked) begin
                    dev_id_nx = iic_rddb;
                    state_nx  = S_CHK;
                end
            end
            S_CHK: begin
                state_nx  = dev_id == 8'hE5 ? S_INIT : S_HALT;
                id_err_nx = dev_id != 8'hE5;
            end
            S_INIT: begin
                if (acked) begin
                    idx_nx       = idx == 3'd2 ? 3'd0 : idx + 3'd1;
                    state_nx     = idx == 3'd2 ? S_IDLE : S_INIT;
                    init_done_nx = idx == 3'd2;
                end else if (can_issue) begin
                    wr_nx   = 1'b1;
                    addr_nx = idx == 3'd0 ? 8'h31 : idx == 3'd1 ? 8'h2D : 8'h2C;
                    wrdb_nx = idx == 3'd0 ? 8'h0B : idx == 3'd1 ? 8'h08 : 8'h0A;
                end
            end
            S_IDLE: begin
                cnt_nx   = sat ? (enable ? 24'd0 : cnt) : cnt + 24'd1;
                state_nx = sat && enable ? S_READ : S_IDLE;
            end
            S_READ: begin
                if (acked) begin
                    stage_nx[{idx, 3'b000} +: 8] = iic_rddb;
                    idx_nx   = idx == 3'd5 ? 3'd0 : idx + 3'd1;
                    state_nx = idx == 3'd5 ? S_DONE : S_READ;
                end else if (can_issue) begin
                    rd_nx   = 1'b1;
                    addr_nx = 8'h32 + {5'd0, idx};
                end
            end
            S_DONE: begin
                // staging holds low byte first: {z_hi, z_lo, y_hi, y_lo, x_hi, x_lo}
                acc_x_nx = stage[15:0];
                acc_y_nx = stage[31:16];
                acc_z_nx = stage[47:32];
                dv_nx    = 1'b1;
                state_nx = S_IDLE;
            end
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_WAIT;
        endcase
    end
endmodule
